// File: rtl/dcache_port_sched.sv
// Single-port L1 data cache access scheduler: loads from the memory pipeline,
// committed stores through an in-order store commit buffer, one access per cycle.
module dcache_port_sched #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int SIZE_W       = 2,
    parameter int SCB_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ld_valid_i,
    input  logic [ADDR_W-1:0]            ld_addr_i,
    input  logic [SIZE_W-1:0]            ld_size_i,
    input  logic                         ld_sign_i,
    output logic                         ld_ready_o,
    input  logic                         st_valid_i,
    input  logic [ADDR_W-1:0]            st_addr_i,
    input  logic [DATA_W-1:0]            st_data_i,
    input  logic [SIZE_W-1:0]            st_size_i,
    output logic                         st_ready_o,
    output logic                         dc_rdEn_o,
    output logic [ADDR_W-1:0]            dc_rdAddr_o,
    output logic [SIZE_W-1:0]            dc_ldSize_o,
    output logic                         dc_ldSign_o,
    output logic                         dc_wrEn_o,
    output logic [ADDR_W-1:0]            dc_wrAddr_o,
    output logic [DATA_W-1:0]            dc_wrData_o,
    output logic [SIZE_W-1:0]            dc_stSize_o,
    input  logic                         dc_rdHit_i,
    input  logic [DATA_W-1:0]            dc_rdData_i,
    output logic                         ld_data_valid_o,
    output logic [DATA_W-1:0]            ld_data_o,
    output logic [$clog2(SCB_DEPTH):0]   scb_count_o,
    output logic                         scb_empty_o
);

    localparam int PTR_W = $clog2(SCB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SIZE_W-1:0] size;
    } scbEntry_t;

    typedef enum logic [1:0] {IDLE, LOAD, STORE, RETRY} state_t;

    state_t             state, stateNext;
    scbEntry_t          scb [SCB_DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count;
    logic [STV_W-1:0]   starveCnt;
    logic               scbFull, scbNonEmpty, enq, conflict;
    logic               readPending, readHit, issueStore, grantLoad;

    assign scbFull     = (count == CNT_W'(SCB_DEPTH));
    assign scbNonEmpty = (count != '0);
    assign enq         = st_valid_i & ~scbFull;
    assign readPending = (state == LOAD) || (state == RETRY);
    assign readHit     = readPending & dc_rdHit_i;

    assign st_ready_o  = ~scbFull;
    assign ld_ready_o  = grantLoad;
    assign scb_count_o = count;
    assign scb_empty_o = ~scbNonEmpty;

    // Word-granular match against every live entry plus the store entering this cycle.
    always_comb begin
        conflict = enq && (st_addr_i[ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2]);
        for (int i = 0; i < SCB_DEPTH; i++) begin
            if ((CNT_W'(i) < count) &&
                (scb[head + PTR_W'(i)].addr[ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2]))
                conflict = 1'b1;
        end
    end

    always_comb begin
        stateNext  = IDLE;
        issueStore = 1'b0;
        grantLoad  = 1'b0;
        if (readPending && !dc_rdHit_i) begin
            stateNext = RETRY;
        end else if (scbNonEmpty && (scbFull || (starveCnt == STV_W'(STARVE_LIMIT)) ||
                                     (ld_valid_i && conflict))) begin
            issueStore = 1'b1;
            stateNext  = STORE;
        end else if (ld_valid_i && !conflict) begin
            grantLoad = 1'b1;
            stateNext = LOAD;
        end else if (scbNonEmpty) begin
            issueStore = 1'b1;
            stateNext  = STORE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // Payload storage needs no reset; liveness is tracked by head/count.
    always_ff @(posedge clk) begin
        if (enq) scb[tail] <= '{addr: st_addr_i, data: st_data_i, size: st_size_i};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            starveCnt <= '0;
        end else begin
            if (enq)        tail <= tail + 1'b1;
            if (issueStore) head <= head + 1'b1;
            count <= count + CNT_W'(enq) - CNT_W'(issueStore);
            if (!scbNonEmpty || issueStore)
                starveCnt <= '0;
            else if (grantLoad && (starveCnt != STV_W'(STARVE_LIMIT)))
                starveCnt <= starveCnt + 1'b1;
        end
    end

    // Read fields are held on a miss so the replay is bit-identical.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dc_rdEn_o       <= 1'b0;
            dc_rdAddr_o     <= '0;
            dc_ldSize_o     <= '0;
            dc_ldSign_o     <= 1'b0;
            dc_wrEn_o       <= 1'b0;
            dc_wrAddr_o     <= '0;
            dc_wrData_o     <= '0;
            dc_stSize_o     <= '0;
            ld_data_valid_o <= 1'b0;
            ld_data_o       <= '0;
        end else begin
            if (issueStore) begin
                dc_rdEn_o   <= 1'b0;
                dc_wrEn_o   <= 1'b1;
                dc_wrAddr_o <= scb[head].addr;
                dc_wrData_o <= scb[head].data;
                dc_stSize_o <= scb[head].size;
            end else if (grantLoad) begin
                dc_rdEn_o   <= 1'b1;
                dc_rdAddr_o <= ld_addr_i;
                dc_ldSize_o <= ld_size_i;
                dc_ldSign_o <= ld_sign_i;
                dc_wrEn_o   <= 1'b0;
            end else if (stateNext == RETRY) begin
                dc_rdEn_o <= 1'b1;
                dc_wrEn_o <= 1'b0;
            end else begin
                dc_rdEn_o <= 1'b0;
                dc_wrEn_o <= 1'b0;
            end
            ld_data_valid_o <= readHit;
            if (readHit) ld_data_o <= dc_rdData_i;
        end
    end

endmodule

// File: tb/tb_dcache_port_sched.sv
// Directed bench for dcache_port_sched with a small cache model behind the port.
module tb_dcache_port_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        ldValid, ldSign, ldReady;
    logic [31:0] ldAddr;
    logic [1:0]  ldSize;
    logic        stValid, stReady;
    logic [31:0] stAddr, stData;
    logic [1:0]  stSize;
    logic        dcRdEn, dcLdSign, dcWrEn, dcRdHit;
    logic [31:0] dcRdAddr, dcWrAddr, dcWrData, dcRdData;
    logic [1:0]  dcLdSize, dcStSize;
    logic        ldDataValid, scbEmpty;
    logic [31:0] ldData;
    logic [2:0]  scbCount;

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    dcache_port_sched dut (
        .clk(clk), .reset(reset),
        .ld_valid_i(ldValid), .ld_addr_i(ldAddr), .ld_size_i(ldSize), .ld_sign_i(ldSign),
        .ld_ready_o(ldReady),
        .st_valid_i(stValid), .st_addr_i(stAddr), .st_data_i(stData), .st_size_i(stSize),
        .st_ready_o(stReady),
        .dc_rdEn_o(dcRdEn), .dc_rdAddr_o(dcRdAddr), .dc_ldSize_o(dcLdSize), .dc_ldSign_o(dcLdSign),
        .dc_wrEn_o(dcWrEn), .dc_wrAddr_o(dcWrAddr), .dc_wrData_o(dcWrData), .dc_stSize_o(dcStSize),
        .dc_rdHit_i(dcRdHit), .dc_rdData_i(dcRdData),
        .ld_data_valid_o(ldDataValid), .ld_data_o(ldData),
        .scb_count_o(scbCount), .scb_empty_o(scbEmpty)
    );

    // Cache model: unwritten words read back as 0xC0DE0000 | word index.
    logic [31:0]   mem [1024];
    logic [1023:0] memVld = '0;
    logic [9:0]    rdIdx;
    assign rdIdx    = dcRdAddr[11:2];
    assign dcRdData = memVld[rdIdx] ? mem[rdIdx] : (32'hC0DE_0000 | {22'd0, rdIdx});

    always @(posedge clk) begin
        if (dcWrEn) begin
            mem[dcWrAddr[11:2]]    <= dcWrData;
            memVld[dcWrAddr[11:2]] <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleReset(input string tag);
        check({tag, "_rdEn"}, 64'(dcRdEn), 64'd0);
        check({tag, "_wrEn"}, 64'(dcWrEn), 64'd0);
        check({tag, "_rdAddr"}, 64'(dcRdAddr), 64'd0);
        check({tag, "_wrAddr"}, 64'(dcWrAddr), 64'd0);
        check({tag, "_wrData"}, 64'(dcWrData), 64'd0);
        check({tag, "_ldVld"}, 64'(ldDataValid), 64'd0);
        check({tag, "_ldData"}, 64'(ldData), 64'd0);
        check({tag, "_cnt"}, 64'(scbCount), 64'd0);
        check({tag, "_empty"}, 64'(scbEmpty), 64'd1);
        check({tag, "_stRdy"}, 64'(stReady), 64'd1);
    endtask

    initial begin
        reset = 1'b0; ldValid = 1'b0; ldAddr = '0; ldSize = 2'd2; ldSign = 1'b0;
        stValid = 1'b0; stAddr = '0; stData = '0; stSize = 2'd2; dcRdHit = 1'b1;

        // Reset state
        #1;
        checkIdleReset("rst");
        tick(); tick();
        checkIdleReset("rst_hold");
        reset = 1'b1;
        tick();
        check("post_rst_rdEn", 64'(dcRdEn), 64'd0);
        check("post_rst_wrEn", 64'(dcWrEn), 64'd0);

        // Single load hit to 0x100
        ldValid = 1'b1; ldAddr = 32'h100; ldSign = 1'b1;
        #1 check("t1_ldRdy", 64'(ldReady), 64'd1);
        tick();
        ldValid = 1'b0;
        check("t1_rdEn", 64'(dcRdEn), 64'd1);
        check("t1_rdAddr", 64'(dcRdAddr), 64'h100);
        check("t1_ldSize", 64'(dcLdSize), 64'd2);
        check("t1_ldSign", 64'(dcLdSign), 64'd1);
        check("t1_ldVld_early", 64'(ldDataValid), 64'd0);
        tick();
        check("t1_ldVld", 64'(ldDataValid), 64'd1);
        check("t1_ldData", 64'(ldData), 64'hC0DE_0040);
        check("t1_rdEn_off", 64'(dcRdEn), 64'd0);
        tick();
        check("t1_ldVld_pulse", 64'(ldDataValid), 64'd0);
        ldSign = 1'b0;

        // Fill SCB while a missing load holds the port, then drain in order
        ldValid = 1'b1; ldAddr = 32'h140;
        #1 check("t2_ldRdy", 64'(ldReady), 64'd1);
        tick();
        ldValid = 1'b0; dcRdHit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            stValid = 1'b1; stAddr = 32'h300 + 32'(4 * k); stData = 32'h1111_0000 + 32'(k);
            #1 check("t2_stRdy", 64'(stReady), 64'd1);
            tick();
        end
        stValid = 1'b0;
        check("t2_full_cnt", 64'(scbCount), 64'd4);
        check("t2_full_stRdy", 64'(stReady), 64'd0);
        check("t2_retry_rdEn", 64'(dcRdEn), 64'd1);
        check("t2_retry_addr", 64'(dcRdAddr), 64'h140);
        check("t2_no_wr", 64'(dcWrEn), 64'd0);
        dcRdHit = 1'b1;
        tick();
        check("t2_ldVld", 64'(ldDataValid), 64'd1);
        check("t2_ldData", 64'(ldData), 64'hC0DE_0050);
        check("t2_rdEn_off", 64'(dcRdEn), 64'd0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            check("t2_wrEn", 64'(dcWrEn), 64'd1);
            check("t2_wrAddr", 64'(dcWrAddr), 64'(32'h300 + 32'(4 * k)));
            check("t2_wrData", 64'(dcWrData), 64'(32'h1111_0000 + 32'(k)));
            check("t2_cnt", 64'(scbCount), 64'(3 - k));
        end
        check("t2_empty", 64'(scbEmpty), 64'd1);
        check("t2_stRdy_again", 64'(stReady), 64'd1);
        tick();
        check("t2_wr_done", 64'(dcWrEn), 64'd0);

        // Load to 0x202 blocked by pending store to 0x200
        stValid = 1'b1; stAddr = 32'h200; stData = 32'hDEAD_BEEF;
        tick();
        stValid = 1'b0; ldValid = 1'b1; ldAddr = 32'h202;
        #1 check("t3_blocked", 64'(ldReady), 64'd0);
        tick();
        check("t3_wrEn", 64'(dcWrEn), 64'd1);
        check("t3_wrAddr", 64'(dcWrAddr), 64'h200);
        check("t3_rdEn_off", 64'(dcRdEn), 64'd0);
        #1 check("t3_granted", 64'(ldReady), 64'd1);
        tick();
        ldValid = 1'b0;
        check("t3_rdAddr", 64'(dcRdAddr), 64'h202);
        tick();
        check("t3_ldVld", 64'(ldDataValid), 64'd1);
        check("t3_fwd_data", 64'(ldData), 64'hDEAD_BEEF);

        // Conflict with a store entering the SCB in the same cycle
        stValid = 1'b1; stAddr = 32'h204; stData = 32'h1234_5678; ldValid = 1'b1; ldAddr = 32'h204;
        #1 check("t3b_enq_conflict", 64'(ldReady), 64'd0);
        tick();
        stValid = 1'b0;
        #1 check("t3b_still_blocked", 64'(ldReady), 64'd0);
        tick();
        check("t3b_wrAddr", 64'(dcWrAddr), 64'h204);
        #1 check("t3b_granted", 64'(ldReady), 64'd1);
        tick();
        ldValid = 1'b0;
        tick();
        check("t3b_data", 64'(ldData), 64'h1234_5678);

        // Store starvation bound under continuous loads
        stValid = 1'b1; stAddr = 32'h400; stData = 32'h5555_0000;
        tick();
        stValid = 1'b0; ldValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ldAddr = 32'h500 + 32'(4 * i);
            #1 check("t4_grant", 64'(ldReady), 64'd1);
            tick();
            check("t4_no_wr", 64'(dcWrEn), 64'd0);
        end
        #1 check("t4_starved", 64'(ldReady), 64'd0);
        tick();
        check("t4_wrEn", 64'(dcWrEn), 64'd1);
        check("t4_wrAddr", 64'(dcWrAddr), 64'h400);
        check("t4_rdEn_off", 64'(dcRdEn), 64'd0);
        #1 check("t4_resume", 64'(ldReady), 64'd1);
        tick();
        check("t4_resume_rd", 64'(dcRdEn), 64'd1);
        ldValid = 1'b0;
        tick(); tick();

        // Three misses then a hit
        ldValid = 1'b1; ldAddr = 32'h600;
        #1 check("t5_ldRdy", 64'(ldReady), 64'd1);
        tick();
        dcRdHit = 1'b0; ldAddr = 32'h700;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_rdEn", 64'(dcRdEn), 64'd1);
            check("t5_rdAddr", 64'(dcRdAddr), 64'h600);
            check("t5_ldRdy_miss", 64'(ldReady), 64'd0);
            check("t5_noVld", 64'(ldDataValid), 64'd0);
            tick();
        end
        ldValid = 1'b0; dcRdHit = 1'b1;
        check("t5_rdEn4", 64'(dcRdEn), 64'd1);
        check("t5_rdAddr4", 64'(dcRdAddr), 64'h600);
        tick();
        check("t5_ldVld", 64'(ldDataValid), 64'd1);
        check("t5_ldData", 64'(ldData), 64'hC0DE_0180);
        check("t5_rdEn_off", 64'(dcRdEn), 64'd0);
        tick();
        check("t5_pulse", 64'(ldDataValid), 64'd0);

        // Reset mid-retry with two buffered stores
        ldValid = 1'b1; ldAddr = 32'h800;
        tick();
        ldValid = 1'b0; dcRdHit = 1'b0;
        stValid = 1'b1; stAddr = 32'h900; stData = 32'hAAAA_0001;
        tick();
        stAddr = 32'h904; stData = 32'hAAAA_0002;
        tick();
        stValid = 1'b0;
        check("t6_cnt", 64'(scbCount), 64'd2);
        check("t6_retry", 64'(dcRdEn), 64'd1);
        #1 reset = 1'b0;
        #1 checkIdleReset("t6_rst");
        tick(); tick();
        reset = 1'b1; dcRdHit = 1'b1;
        tick();
        check("t6_post_rdEn", 64'(dcRdEn), 64'd0);
        check("t6_post_wrEn", 64'(dcWrEn), 64'd0);
        check("t6_post_cnt", 64'(scbCount), 64'd0);
        tick();
        check("t6_post_wrEn2", 64'(dcWrEn), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
